// File: rtl/fifo_defs_pkg.sv
// fifo_defs: address-width derivation and parameter-legality checks for fifo_queue_param
package fifo_defs;
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction
  function automatic bit params_ok(input int dw, input int depth, input int afl, input int ael);
    return dw >= 1 && depth >= 2 && (depth & (depth - 1)) == 0 &&
           afl >= 1 && afl <= depth && ael >= 0 && ael < depth;
  endfunction
endpackage

// File: rtl/fifo_memory_dp.sv
// fifo_memory_dp: DEPTH x DW register array, synchronous write, registered read with clear
module fifo_memory_dp import fifo_defs::*; #(
  parameter int DW = 32,
  parameter int DEPTH = 8,
  localparam int AW = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk)
    if (clr) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/fifo_queue_param.sv
// fifo_queue_param: parametrised synchronous FIFO with fill count, thresholds and sticky error flags
module fifo_queue_param import fifo_defs::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                         Clk_In,
  input  logic                         Reset_In,
  input  logic                         Clear_In,
  input  logic [DATA_WIDTH-1:0]        Data_In,
  input  logic                         Write_Enable_In,
  input  logic                         Read_Enable_In,
  output logic [DATA_WIDTH-1:0]        Data_Out,
  output logic                         Data_Valid_Out,
  output logic                         FIFO_Empty,
  output logic                         FIFO_Full,
  output logic                         FIFO_Almost_Full,
  output logic                         FIFO_Almost_Empty,
  output logic [$clog2(DEPTH):0]       Fill_Count,
  output logic                         Overflow,
  output logic                         Underflow
);
  localparam int AW = addr_width(DEPTH);
  localparam int CW = AW + 1;
  if (!params_ok(DATA_WIDTH, DEPTH, ALMOST_FULL_LEVEL, ALMOST_EMPTY_LEVEL)) begin : g_bad_params
    $error("fifo_queue_param: illegal parameter combination");
  end
  logic [AW:0] wr_ptr, rd_ptr;
  logic rd_ok, wr_ok, clr;
  assign clr = Reset_In || Clear_In;
  assign FIFO_Empty = Fill_Count == '0;
  assign FIFO_Full = Fill_Count == CW'(DEPTH);
  assign FIFO_Almost_Full = Fill_Count >= CW'(ALMOST_FULL_LEVEL);
  assign FIFO_Almost_Empty = Fill_Count <= CW'(ALMOST_EMPTY_LEVEL);
  assign rd_ok = Read_Enable_In && !FIFO_Empty;
  // a read on a full FIFO frees the slot the simultaneous write lands in
  assign wr_ok = Write_Enable_In && (!FIFO_Full || rd_ok);
  always_ff @(posedge Clk_In)
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Fill_Count <= '0;
      Data_Valid_Out <= 1'b0;
      Overflow <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + CW'(wr_ok);
      rd_ptr <= rd_ptr + CW'(rd_ok);
      Fill_Count <= Fill_Count + CW'(wr_ok) - CW'(rd_ok);
      Data_Valid_Out <= rd_ok;
      Overflow <= Overflow || (Write_Enable_In && !wr_ok);
      Underflow <= Underflow || (Read_Enable_In && !rd_ok);
    end
  fifo_memory_dp #(.DW(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(Clk_In),
    .clr(clr),
    .we(wr_ok && !clr),
    .wa(wr_ptr[AW-1:0]),
    .wd(Data_In),
    .re(rd_ok && !clr),
    .ra(rd_ptr[AW-1:0]),
    .rd(Data_Out)
  );
endmodule

// File: tb/tb_fifo_queue_param.sv
// tb_fifo_queue_param: randomized scoreboard bench against a queue-based reference model
module tb_fifo_queue_param;
  localparam int DW = 32, DEPTH = 8, AFL = 6, AEL = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, clr, we, re;
  logic [DW-1:0] din, dout;
  logic dvalid, empty, full, afull, aempty, ovf, unf;
  logic [$clog2(DEPTH):0] fill;
  fifo_queue_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)) dut (
    .Clk_In(clk), .Reset_In(rst), .Clear_In(clr), .Data_In(din),
    .Write_Enable_In(we), .Read_Enable_In(re), .Data_Out(dout), .Data_Valid_Out(dvalid),
    .FIFO_Empty(empty), .FIFO_Full(full), .FIFO_Almost_Full(afull), .FIFO_Almost_Empty(aempty),
    .Fill_Count(fill), .Overflow(ovf), .Underflow(unf)
  );
  logic [DW-1:0] mq[$], exp_q[$];
  logic [DW-1:0] last;
  bit ov_m, un_m, v_m, run;
  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, act, req, $time);
    end
  endtask
  task automatic step(input bit r, input bit c, input bit w, input bit rd, input logic [DW-1:0] d);
    bit rok, wok;
    rst = r; clr = c; we = w; re = rd; din = d;
    @(posedge clk);
    if (r || c) begin
      mq.delete(); exp_q.delete();
      ov_m = 0; un_m = 0; v_m = 0; last = '0;
    end else begin
      rok = rd && mq.size() > 0;
      wok = w && (mq.size() < DEPTH || rok);
      v_m = rok;
      if (rok) begin
        last = mq.pop_front();
        exp_q.push_back(last);
      end
      if (wok) mq.push_back(d);
      ov_m = ov_m || (w && !wok);
      un_m = un_m || (rd && !rok);
    end
    @(negedge clk);
  endtask
  always @(negedge clk) if (run) begin
    chk("fill_count", 64'(fill), 64'(mq.size()));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("almost_full", 64'(afull), 64'(mq.size() >= AFL));
    chk("almost_empty", 64'(aempty), 64'(mq.size() <= AEL));
    chk("overflow", 64'(ovf), 64'(ov_m));
    chk("underflow", 64'(unf), 64'(un_m));
    chk("data_valid", 64'(dvalid), 64'(v_m));
    if (dvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdata got %0h want no output at %0t", dout, $time);
      end else chk("rdata", 64'(dout), 64'(exp_q.pop_front()));
    end
    chk("data_out_hold", 64'(dout), 64'(last));
  end
  initial begin
    int pw, pr;
    rst = 1; clr = 0; we = 0; re = 0; din = '0; last = '0;
    @(negedge clk);
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    run = 1;
    step(0, 0, 0, 0, '0);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 0, DW'(i * 'h11));
    step(0, 0, 1, 0, 'h99);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 0, DW'(i * 'h11));
    step(0, 0, 1, 1, 'hAA);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, '0);
    step(0, 0, 1, 1, 'h55);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, i % 4 != 0, $urandom);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, '0);
    step(0, 0, 0, 1, '0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, $urandom);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, '0);
    step(0, 1, 1, 1, 'hDEAD);
    step(0, 0, 1, 0, 'h77);
    step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, $urandom);
    step(1, 0, 1, 1, 'hBEEF);
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < 600; i++) begin
      pw = (i / 50) % 2 ? 75 : 30;
      pr = 100 - pw;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, $urandom);
    end
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_queue_param.md
# fifo_queue_param

Parametrised synchronous FIFO queue: the next-generation general-purpose buffer for the data-storage library. It adds configurable width and depth, fill count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a read-valid strobe. Everything runs in one clock domain. It sits between any producer/consumer pair that need elastic buffering.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits (≥1).
- DEPTH, 8, number of entries; must be a power of two, ≥2.
- ALMOST_FULL_LEVEL, DEPTH-2, Fill_Count at or above which FIFO_Almost_Full asserts (1..DEPTH).
- ALMOST_EMPTY_LEVEL, 2, Fill_Count at or below which FIFO_Almost_Empty asserts (0..DEPTH-1).

Ports:
- Clk_In, input, 1, single clock; all state updates on the rising edge.
- Reset_In, input, 1, synchronous, active-high reset.
- Clear_In, input, 1, synchronous flush; empties the FIFO and clears the error flags.
- Data_In, input, DATA_WIDTH, write data.
- Write_Enable_In, input, 1, write request.
- Read_Enable_In, input, 1, read request.
- Data_Out, output, DATA_WIDTH, registered read data.
- Data_Valid_Out, output, 1, one-cycle strobe: Data_Out updated by an accepted read.
- FIFO_Empty, output, 1, Fill_Count == 0.
- FIFO_Full, output, 1, Fill_Count == DEPTH.
- FIFO_Almost_Full, output, 1, Fill_Count ≥ ALMOST_FULL_LEVEL.
- FIFO_Almost_Empty, output, 1, Fill_Count ≤ ALMOST_EMPTY_LEVEL.
- Fill_Count, output, $clog2(DEPTH)+1, current occupancy, 0..DEPTH.
- Overflow, output, 1, sticky: a write was rejected because the FIFO was full.
- Underflow, output, 1, sticky: a read was rejected because the FIFO was empty.

## Operation
- Pointers: write and read pointers are each ADDR_WIDTH+1 bits wide, with ADDR_WIDTH = $clog2(DEPTH). The low ADDR_WIDTH bits index memory. Pointers wrap naturally modulo 2·DEPTH.
- Fill_Count is a registered counter:
  - +1 on write-only.
  - −1 on read-only.
  - Unchanged when both or neither access is accepted.
- All status flags decode combinationally from Fill_Count.
- Read acceptance: rd_ok = Read_Enable_In && !FIFO_Empty. There is no bypass: a read on an empty FIFO is rejected even if a write arrives in the same cycle.
- Write acceptance: wr_ok = Write_Enable_In && (!FIFO_Full || rd_ok). When full, a simultaneous accepted read frees the slot, so both accesses proceed and Fill_Count stays at DEPTH.
- Accepted write: mem[wr_ptr] ← Data_In, then wr_ptr+1.
- Accepted read: Data_Out ← mem[rd_ptr], rd_ptr+1, and Data_Valid_Out=1 on the next cycle.
- No read: Data_Out holds its last value (never Z) and Data_Valid_Out=0.
- Error flags:
  - Overflow sets on Write_Enable_In && !wr_ok.
  - Underflow sets on Read_Enable_In && !rd_ok.
  - Both hold until Reset_In or Clear_In.
- Priority: Reset_In > Clear_In > read/write. Clear_In zeroes the pointers, Fill_Count, Data_Valid_Out, Overflow, Underflow and Data_Out. Any read or write in the clearing cycle is ignored and sets no error flag.
- Memory contents are not reset.

## Timing
- Reset values: Data_Out=0, Data_Valid_Out=0, Fill_Count=0, FIFO_Empty=1, FIFO_Almost_Empty=1, FIFO_Full=0, FIFO_Almost_Full=0, Overflow=0, Underflow=0.
- Write latency: data written at edge N is readable by a read request in cycle N+1. FIFO_Empty deasserts immediately after edge N.
- Read latency: 1 cycle. A request sampled at edge N presents data and Data_Valid_Out after edge N.
- Full-to-empty throughput: one read and one write per cycle, sustained indefinitely without data loss.
- Reset or clear asserted mid-burst takes effect at that edge. The first accepted write after release lands at address 0.

## Structure
- A shared header/package (fifo_defs) holds the ADDR_WIDTH derivation function and the parameter-legality checks (DEPTH power of two, level ranges).
- One sub-module, fifo_memory_dp: a DEPTH×DATA_WIDTH register array with a synchronous write port and a registered read port.
- The top level contains pointers, the counter, flags and acceptance logic.

## Test plan
- Reset, then write 0x11..0x88 (DEPTH=8) → FIFO_Full=1, Fill_Count=8, FIFO_Almost_Full from count 6. A ninth write sets Overflow=1, and the data is not stored.
- Read 8 times → Data_Out 0x11..0x88 in order, Data_Valid_Out high each read cycle, FIFO_Empty=1 after the last. A ninth read sets Underflow=1, and Data_Out holds 0x88.
- Full FIFO, simultaneous read and write of 0xAA → Data_Out=0x11, Fill_Count stays 8, 0xAA later emerges last, Overflow stays 0.
- Empty FIFO, simultaneous read and write of 0x55 → read rejected (Underflow=1), Fill_Count=1, next read returns 0x55.
- 20 interleaved write/read cycles wrapping the pointers twice → output sequence equals input sequence, Fill_Count matches the reference model every cycle.
- Clear_In with Fill_Count=5 and both error flags set → next cycle Fill_Count=0, FIFO_Empty=1, flags 0. Write 0x77 then read → returns 0x77.
